lsu: RTL and testbench

//   Load/store stage directly downstream of the execute stage. Consumes the ALU

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_load_align.sv | 23 ++
 rtl/lsu.sv | 133 +++++++++++++
 tb/tb_lsu.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store stage.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [31:0] RMASK_B = 32'h0000_00FF;
  localparam logic [31:0] RMASK_H = 32'h0000_FFFF;
  localparam logic [31:0] RMASK_W = 32'hFFFF_FFFF;

  // Instruction fields captured on accept; held for the whole transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rsb;
    logic        ren;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] rmask;
    logic        sgn;
  } lsu_op_t;

  // Moves low-order store data up to the byte lane selected by the address offset.
  function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shift word to byte offset, mask, sign-extend.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [31:0] rmask,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [31:0] raw;
  logic [31:0] masked;

  always_comb begin
    raw    = rdata >> {offset, 3'b000};
    masked = raw & rmask;
    data   = masked;
    if (sgn && rmask == RMASK_B)      data = {{24{masked[7]}}, masked[7:0]};
    else if (sgn && rmask == RMASK_H) data = {{16{masked[15]}}, masked[15:0]};
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one instruction in flight, valid/ready memory port.
// Optional LSU_MISALIGN_CHECK_EN: flag misaligned half/word and skip memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int CTRL_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_receive_valid,
  output logic              lsu_send_ready,
  input  logic [31:0]       alu_result_input,
  input  logic [31:0]       rsb_input,
  input  logic              ren_input,
  input  logic              wen_input,
  input  logic [7:0]        wmask_input,
  input  logic [31:0]       rmask_input,
  input  logic              memory_read_signed_input,
  input  logic [CTRL_W-1:0] ctrl_input,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_rdata,
  output logic              lsu_send_valid,
  input  logic              lsu_receive_ready,
  output logic [31:0]       lsu_result,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic              lsu_misaligned,
`endif
  output logic [CTRL_W-1:0] ctrl
);

  lsu_state_t        state, state_nxt;
  lsu_op_t           op_q;
  logic [31:0]       result_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              send_ready_q;
  logic              accept;
  logic              is_mem;
  logic              mis_in;
  logic [31:0]       load_data;
  logic              unused_bits;

  assign accept      = (state == IDLE) && lsu_receive_valid;
  assign is_mem      = ren_input | wen_input;
  assign unused_bits = ^wmask_input[7:4];

`ifdef LSU_MISALIGN_CHECK_EN
  logic is_h, is_w, mis_q;
  // Access size comes from rmask for loads and from the byte mask for stores.
  assign is_h   = ren_input ? (rmask_input == RMASK_H) : (wmask_input[3:0] == 4'h3);
  assign is_w   = ren_input ? (rmask_input == RMASK_W) : (wmask_input[3:0] == 4'hF);
  assign mis_in = is_mem & ((is_h & alu_result_input[0]) |
                            (is_w & (alu_result_input[1:0] != 2'b00)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        mis_q <= 1'b0;
    else if (accept) mis_q <= mis_in;
  end

  assign lsu_misaligned = mis_q & (state == DONE);
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lsu_receive_valid) state_nxt = (is_mem && !mis_in) ? REQ : DONE;
      REQ:     if (mem_req_ready)     state_nxt = WAIT;
      WAIT:    if (mem_resp_valid)    state_nxt = DONE;
      DONE:    if (lsu_receive_ready) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q         <= '0;
      result_q     <= '0;
      ctrl_q       <= '0;
      send_ready_q <= 1'b0;
    end else begin
      send_ready_q <= accept;
      if (accept) begin
        op_q.addr  <= alu_result_input;
        op_q.rsb   <= rsb_input;
        op_q.ren   <= ren_input;
        op_q.wen   <= wen_input;
        op_q.wmask <= wmask_input[3:0];
        op_q.rmask <= rmask_input;
        op_q.sgn   <= memory_read_signed_input;
        ctrl_q     <= ctrl_input;
        // Stores and pass-through ops report the ALU result; loads overwrite it later.
        result_q   <= mis_in ? '0 : alu_result_input;
      end else if (state == WAIT && mem_resp_valid && op_q.ren) begin
        result_q <= load_data;
      end
    end
  end

  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .offset (op_q.addr[1:0]),
    .rmask  (op_q.rmask),
    .sgn    (op_q.sgn),
    .data   (load_data)
  );

  // A load that also claims to be a store is treated as a load.
  assign mem_req_valid  = (state == REQ);
  assign mem_addr       = {op_q.addr[31:2], 2'b00};
  assign mem_wen        = op_q.wen & ~op_q.ren;
  assign mem_wdata      = lane_shift(op_q.rsb, op_q.addr[1:0]);
  assign mem_wstrb      = op_q.wmask << op_q.addr[1:0];
  assign lsu_send_ready = send_ready_q;
  assign lsu_send_valid = (state == DONE);
  assign lsu_result     = result_q;
  assign ctrl           = ctrl_q;

  ren_wen_excl: assert property (@(posedge clk) disable iff (!rst)
    accept |-> !(ren_input && wen_input));

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes expectations, monitor checks DUT outputs.
module tb_lsu;
  localparam int CTRL_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              lsu_receive_valid;
  logic              lsu_send_ready;
  logic [31:0]       alu_result_input, rsb_input, rmask_input;
  logic              ren_input, wen_input, memory_read_signed_input;
  logic [7:0]        wmask_input;
  logic [CTRL_W-1:0] ctrl_input;
  logic              mem_req_valid, mem_req_ready;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic              mem_wen, mem_resp_valid;
  logic [3:0]        mem_wstrb;
  logic              lsu_send_valid, lsu_receive_ready;
  logic [31:0]       lsu_result;
  logic [CTRL_W-1:0] ctrl;
`ifdef LSU_MISALIGN_CHECK_EN
  logic              lsu_misaligned;
`endif

  lsu #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
    .alu_result_input(alu_result_input), .rsb_input(rsb_input),
    .ren_input(ren_input), .wen_input(wen_input), .wmask_input(wmask_input),
    .rmask_input(rmask_input), .memory_read_signed_input(memory_read_signed_input),
    .ctrl_input(ctrl_input),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
    .lsu_result(lsu_result),
`ifdef LSU_MISALIGN_CHECK_EN
    .lsu_misaligned(lsu_misaligned),
`endif
    .ctrl(ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] res; logic [CTRL_W-1:0] ctl;} exp_t;
  typedef struct {logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  typedef struct {
    logic [31:0] addr; logic [31:0] rsb; logic ren; logic wen;
    int size; logic sgn; logic [CTRL_W-1:0] ctl; logic [31:0] rdata;
  } op_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, hs_cnt = 0, first_sv = 0;
  int req_wait_cfg = 0, resp_wait_cfg = 0, rr_wait_cfg = 0;
  bit spur_cfg = 0;
  logic [31:0] rdata_cfg = '0;
  bit prev_hs = 0, prev_rhs = 0, prev_sv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: pick the addressed bytes, then widen by access size and signedness.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input int size, input logic sgn);
    logic [31:0] w;
    logic signed [7:0] b8;
    logic signed [15:0] h16;
    int v;
    w = word >> (8 * off);
    b8 = w[7:0];
    h16 = w[15:0];
    case (size)
      0: begin v = b8;  return sgn ? v : {24'b0, w[7:0]}; end
      1: begin v = h16; return sgn ? v : {16'b0, w[15:0]}; end
      default: return w;
    endcase
  endfunction

  function automatic void ref_store(input logic [31:0] rsb, input logic [1:0] off,
                                    input logic [3:0] wm, output logic [31:0] wd,
                                    output logic [3:0] ws);
    wd = '0; ws = '0;
    for (int b = 0; b < 4; b++)
      if (b >= int'(off)) begin
        wd[8*b +: 8] = rsb[8*(b-int'(off)) +: 8];
        ws[b] = wm[b-int'(off)];
      end
  endfunction

  function automatic logic [3:0] size_wmask(input int size);
    return (size == 0) ? 4'h1 : (size == 1) ? 4'h3 : 4'hF;
  endfunction

  function automatic logic [31:0] size_rmask(input int size);
    return (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  // Memory model: optional accept stall, response a programmable number of cycles later.
  initial begin
    int sc, rc;
    sc = 0; rc = -1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 0;
      if (!rst) begin mem_req_ready = 0; sc = 0; rc = -1; continue; end
      if (mem_req_ready) begin mem_req_ready = 0; rc = resp_wait_cfg; hs_cnt++; end
      if (rc == 0) begin mem_resp_valid = 1; mem_rdata = rdata_cfg; rc = -1; end
      else if (rc > 0) rc--;
      else if (spur_cfg && $urandom_range(1, 0) == 1) begin
        mem_resp_valid = 1; mem_rdata = $urandom;
      end
      if (mem_req_valid && rc < 0) begin
        if (sc >= req_wait_cfg) begin mem_req_ready = 1; sc = 0; end
        else sc++;
      end
    end
  end

  // Writeback model: delays ready by a programmable number of cycles.
  initial begin
    int dc;
    dc = 0;
    lsu_receive_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (lsu_send_valid) begin
        if (dc >= rr_wait_cfg) begin lsu_receive_ready = 1; dc = 0; end
        else begin lsu_receive_ready = 0; dc++; end
      end else begin
        dc = 0;
        lsu_receive_ready = 1'($urandom_range(1, 0));
      end
    end
  end

  // Monitor: compares presented results/requests against the scoreboard fronts.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin prev_hs = 0; prev_rhs = 0; prev_sv = 0; continue; end
      if (prev_hs)  chk("send_valid_drop", 64'(lsu_send_valid), 64'd0);
      if (prev_rhs) chk("req_valid_drop", 64'(mem_req_valid), 64'd0);
      prev_hs = 0; prev_rhs = 0;
      if (lsu_send_valid && !prev_sv) first_sv = cyc;
      prev_sv = lsu_send_valid;
      if (lsu_send_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=%h expected=none", lsu_result);
        end else begin
          chk("result", 64'(lsu_result), 64'(exp_q[0].res));
          chk("ctrl", ctrl, exp_q[0].ctl);
`ifdef LSU_MISALIGN_CHECK_EN
          chk("misaligned", 64'(lsu_misaligned), 64'd0);
`endif
          if (lsu_receive_ready) begin void'(exp_q.pop_front()); prev_hs = 1; end
        end
      end
      if (mem_req_valid) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=%h expected=none", mem_addr);
        end else begin
          chk("req_addr", 64'(mem_addr), 64'(req_q[0].addr));
          chk("req_wen", 64'(mem_wen), 64'(req_q[0].wen));
          if (req_q[0].wen) begin
            chk("req_wdata", 64'(mem_wdata), 64'(req_q[0].wdata));
            chk("req_wstrb", 64'(mem_wstrb), 64'(req_q[0].wstrb));
          end
          if (mem_req_ready) begin void'(req_q.pop_front()); prev_rhs = 1; end
        end
      end
    end
  end

  task automatic set_inputs(input op_t o);
    alu_result_input = o.addr;
    rsb_input = o.rsb;
    ren_input = o.ren;
    wen_input = o.wen;
    wmask_input = {4'($urandom), size_wmask(o.size)};
    rmask_input = size_rmask(o.size);
    memory_read_signed_input = o.sgn;
    ctrl_input = o.ctl;
  endtask

  task automatic scramble();
    alu_result_input = $urandom; rsb_input = $urandom;
    ren_input = 1'($urandom); wen_input = 1'($urandom);
    wmask_input = 8'($urandom); rmask_input = $urandom;
    memory_read_signed_input = 1'($urandom);
    ctrl_input = {$urandom, $urandom};
  endtask

  // Issues one op (called at posedge+1 with DUT idle) and waits for it to retire.
  task automatic do_op(input op_t o, input int rqw, input int rsw, input int rrw,
                       input bit spur, output int lat);
    bit mem;
    int hs0, c0;
    exp_t e;
    req_t r;
    mem = o.ren | o.wen;
    req_wait_cfg = rqw; resp_wait_cfg = rsw; rr_wait_cfg = rrw; spur_cfg = spur;
    rdata_cfg = o.rdata;
    e.res = o.ren ? ref_load(o.rdata, o.addr[1:0], o.size, o.sgn) : o.addr;
    e.ctl = o.ctl;
    exp_q.push_back(e);
    if (mem) begin
      r.addr = {o.addr[31:2], 2'b00};
      r.wen = o.wen & ~o.ren;
      ref_store(o.rsb, o.addr[1:0], size_wmask(o.size), r.wdata, r.wstrb);
      req_q.push_back(r);
    end
    hs0 = hs_cnt; c0 = cyc;
    set_inputs(o);
    lsu_receive_valid = 1;
    @(posedge clk); @(negedge clk);
    chk("send_ready_pulse", 64'(lsu_send_ready), 64'd1);
    @(posedge clk); #1;
    lsu_receive_valid = 0;
    scramble();
    @(negedge clk);
    chk("send_ready_single", 64'(lsu_send_ready), 64'd0);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL op_timeout actual=pending expected=retired addr=%h", o.addr);
      exp_q.delete(); req_q.delete();
    end
    @(posedge clk); #1;
    lat = first_sv - c0 + 1;
    chk("mem_accepts", 64'(hs_cnt - hs0), mem ? 64'd1 : 64'd0);
  endtask

  function automatic op_t mk(input logic [31:0] addr, input logic [31:0] rsb, input logic ren,
                             input logic wen, input int size, input logic sgn,
                             input logic [31:0] rdata);
    op_t o;
    o.addr = addr; o.rsb = rsb; o.ren = ren; o.wen = wen; o.size = size; o.sgn = sgn;
    o.rdata = rdata; o.ctl = {$urandom, $urandom};
    return o;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_send_ready"}, 64'(lsu_send_ready), 64'd0);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wen"}, 64'(mem_wen), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'd0);
    chk({tag, "_send_valid"}, 64'(lsu_send_valid), 64'd0);
    chk({tag, "_result"}, 64'(lsu_result), 64'd0);
    chk({tag, "_ctrl"}, ctrl, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int lat, hs0, seen, size;
    logic [1:0] off;
    lsu_receive_valid = 0;
    scramble();
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    // Aligned word load, zero-wait memory.
    o = mk(32'h8000_0004, 32'h0, 1, 0, 2, 0, 32'hDEAD_BEEF);
    do_op(o, 0, 0, 0, 0, lat);
    chk("load_latency", 64'(lat), 64'd4);
    // Signed and unsigned byte loads from the top lane.
    do_op(mk(32'h8000_0003, 32'h0, 1, 0, 0, 1, 32'h8011_2233), 0, 0, 0, 0, lat);
    do_op(mk(32'h8000_0003, 32'h0, 1, 0, 0, 0, 32'h8011_2233), 0, 0, 0, 0, lat);
    // Halfword store into the upper lanes.
    do_op(mk(32'h8000_0002, 32'h0000_1234, 0, 1, 1, 0, 32'h0), 0, 0, 0, 0, lat);
    // Memory stall on accept, then delayed response.
    do_op(mk(32'h8000_0020, 32'h0, 1, 0, 1, 1, 32'h0000_8001), 5, 3, 0, 1, lat);
    // Pass-through op, then with writeback back-pressure.
    do_op(mk(32'h0000_0055, 32'h0, 0, 0, 2, 0, 32'h0), 0, 0, 0, 0, lat);
    chk("pass_latency", 64'(lat), 64'd2);
    do_op(mk(32'h0000_0055, 32'h0, 0, 0, 2, 0, 32'h0), 0, 0, 3, 1, lat);

    // Reset while waiting for a load response.
    o = mk(32'h8000_0010, 32'h0, 1, 0, 2, 0, 32'hCAFE_F00D);
    req_wait_cfg = 0; resp_wait_cfg = 10; spur_cfg = 0; rr_wait_cfg = 0;
    req_q.push_back('{32'h8000_0010, 1'b0, 32'h0, 4'h0});
    hs0 = hs_cnt;
    set_inputs(o);
    lsu_receive_valid = 1;
    @(posedge clk); #1;
    lsu_receive_valid = 0;
    for (int i = 0; i < 20 && hs_cnt == hs0; i++) @(negedge clk);
    chk("reset_reached_wait", 64'(hs_cnt - hs0), 64'd1);
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete(); req_q.delete();
    @(posedge clk); @(negedge clk);
    rst = 1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (lsu_send_valid || mem_req_valid) seen++;
    end
    chk("no_orphan_activity", 64'(seen), 64'd0);
    @(posedge clk); #1;
    do_op(mk(32'h8000_0104, 32'h0, 1, 0, 2, 0, 32'h1357_9BDF), 0, 1, 0, 0, lat);

    // Randomized mix of aligned loads, stores and pass-through ops.
    for (int n = 0; n < 60; n++) begin
      size = $urandom_range(2, 0);
      off = (size == 0) ? 2'($urandom) : (size == 1) ? {1'($urandom), 1'b0} : 2'b00;
      o = mk(32'h8000_0000 | ($urandom & 32'h0000_FFFC) | 32'(off), $urandom, 0, 0,
             size, 1'($urandom), $urandom);
      case ($urandom_range(2, 0))
        0: o.ren = 1;
        1: o.wen = 1;
        default: o.addr = $urandom;
      endcase
      do_op(o, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
            1'($urandom), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
